// File: rtl/csr_unit_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, op encodings,
// bit positions and small value helpers.
package csr_unit_pkg;

  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MHPM3         = 12'hB03;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MHPM3H        = 12'hB83;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;

  typedef enum logic [1:0] {
    CSR_OP_READ = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIP_MSIP     = 3;
  localparam int MIP_MTIP     = 7;
  localparam int MIP_MEIP     = 11;

  localparam logic [31:0] IRQ_MASK  = 32'h0000_0888;
  localparam logic [31:0] MEPC_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] csr_apply_op(csr_op_e op, logic [31:0] old_v,
                                               logic [31:0] wdata);
    logic [31:0] res;
    case (op)
      CSR_OP_RW: res = wdata;
      CSR_OP_RS: res = old_v | wdata;
      CSR_OP_RC: res = old_v & ~wdata;
      default:   res = old_v;
    endcase
    return res;
  endfunction

  // RS/RC with a zero operand leave the register untouched.
  function automatic logic csr_op_writes(csr_op_e op, logic [31:0] wdata);
    logic res;
    case (op)
      CSR_OP_RW: res = 1'b1;
      CSR_OP_RS: res = (wdata != 32'd0);
      CSR_OP_RC: res = (wdata != 32'd0);
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] mstatus_pack(logic mie, logic mpie);
    logic [31:0] v;
    v                = 32'd0;
    v[12:11]         = 2'b11;
    v[MSTATUS_MPIE]  = mpie;
    v[MSTATUS_MIE]   = mie;
    return v;
  endfunction

  function automatic logic [31:0] cntinh_mask(int num_hpm);
    logic [31:0] m;
    m = 32'h0000_0005;
    for (int k = 0; k < num_hpm; k++) begin
      m[3+k] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/csr_unit_if.sv
// CSR instruction port between the execute stage (master) and the CSR unit (slave).
interface csr_unit_if;
  import csr_unit_pkg::*;

  logic        csr_req_i;
  csr_op_e     csr_op_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        csr_illegal_o;

  modport master (
    output csr_req_i, csr_op_i, csr_addr_i, csr_wdata_i,
    input  csr_rdata_o, csr_illegal_o
  );

  modport slave (
    input  csr_req_i, csr_op_i, csr_addr_i, csr_wdata_i,
    output csr_rdata_o, csr_illegal_o
  );

endinterface

// File: rtl/csr_unit_counter.sv
// One CNT_WIDTH-bit event counter with 32-bit lo/hi software write ports;
// the read value is zero-filled to 64 bits.
module csr_counter #(
  parameter int CNT_WIDTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  input  logic        inhibit_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] cnt_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [63:0]          cnt_ext_s, wr_lo_full_s, wr_hi_full_s;
  logic                 unused_wr_s;

  // A software write to one half wins over the increment; the other half holds.
  always_comb begin
    cnt_ext_s                  = 64'd0;
    cnt_ext_s[CNT_WIDTH-1:0]   = cnt_q;
    wr_lo_full_s               = {cnt_ext_s[63:32], wdata_i};
    wr_hi_full_s               = {wdata_i, cnt_ext_s[31:0]};
    if (wr_lo_i) begin
      cnt_d = wr_lo_full_s[CNT_WIDTH-1:0];
    end else if (wr_hi_i) begin
      cnt_d = wr_hi_full_s[CNT_WIDTH-1:0];
    end else if (inc_i && !inhibit_i) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o       = cnt_ext_s;
  assign unused_wr_s = ^{wr_lo_full_s, wr_hi_full_s};

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: atomic CSR ops, cycle/instret/hpm counters,
// trap entry / mret handling of mstatus and interrupt request generation.
module csr_unit
  import csr_unit_pkg::*;
#(
  parameter int          CNT_WIDTH = 64,
  parameter int          NUM_HPM   = 0,
  parameter logic [31:0] MTVEC_RST = 32'h0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  csr_unit_if.slave                             csr,
  input  logic                                  instret_i,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event_i,
  input  logic                                  trap_i,
  input  logic [31:0]                           trap_cause_i,
  input  logic [31:0]                           trap_epc_i,
  input  logic                                  mret_i,
  input  logic                                  irq_sw_i,
  input  logic                                  irq_timer_i,
  input  logic                                  irq_ext_i,
  output logic                                  irq_req_o,
  output logic [31:0]                           trap_vec_o,
  output logic [31:0]                           mepc_o,
  output logic [31:0]                           mstatus_o
);

  localparam int          NCNT     = 2 + NUM_HPM;
  localparam logic [31:0] INH_MASK = cntinh_mask(NUM_HPM);

  logic        st_mie_q, st_mie_d, st_mpie_q, st_mpie_d;
  logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mip_q, mip_d;
  logic [31:0] minh_q, minh_d;
  logic        irq_req_q, irq_req_d;

  logic [31:0] rdata_s, wr_val_s, mstatus_s, vec_base_s;
  logic        known_s, illegal_s, wr_en_s;
  logic        cnt_hit_s, cnt_hi_s;
  logic [2:0]  cnt_slot_s;
  logic [4:0]  idx_s;
  logic [63:0] cnt_val_s [8];
  logic [NCNT-1:0] cnt_inc_s, cnt_inh_s, cnt_wr_lo_s, cnt_wr_hi_s;
  logic        unused_hpm_s;

  assign mstatus_s = mstatus_pack(st_mie_q, st_mpie_q);
  assign idx_s     = csr.csr_addr_i[4:0];

  // Address decode and old-value read mux.
  always_comb begin
    rdata_s    = 32'd0;
    known_s    = 1'b1;
    cnt_hit_s  = 1'b0;
    cnt_hi_s   = csr.csr_addr_i[7];
    cnt_slot_s = 3'd0;
    case (csr.csr_addr_i)
      CSR_MSTATUS:       rdata_s = mstatus_s;
      CSR_MIE:           rdata_s = mie_q;
      CSR_MTVEC:         rdata_s = mtvec_q;
      CSR_MCOUNTINHIBIT: rdata_s = minh_q;
      CSR_MSCRATCH:      rdata_s = mscratch_q;
      CSR_MEPC:          rdata_s = mepc_q;
      CSR_MCAUSE:        rdata_s = mcause_q;
      CSR_MIP:           rdata_s = mip_q;
      default: begin
        if ((csr.csr_addr_i[11:8] == 4'hB || csr.csr_addr_i[11:8] == 4'hC) &&
            csr.csr_addr_i[6:5] == 2'b00) begin
          if (idx_s == 5'd0) begin
            cnt_hit_s = 1'b1;
          end else if (idx_s == 5'd2) begin
            cnt_hit_s  = 1'b1;
            cnt_slot_s = 3'd1;
          end else if (csr.csr_addr_i[11:8] == 4'hB && int'(idx_s) >= 3 &&
                       int'(idx_s) < 3 + NUM_HPM) begin
            cnt_hit_s  = 1'b1;
            cnt_slot_s = 3'(idx_s - 5'd1);
          end else begin
            cnt_hit_s = 1'b0;
          end
        end else begin
          cnt_hit_s = 1'b0;
        end
        known_s = cnt_hit_s;
        if (cnt_hit_s) begin
          rdata_s = cnt_hi_s ? cnt_val_s[cnt_slot_s][63:32] : cnt_val_s[cnt_slot_s][31:0];
        end else begin
          rdata_s = 32'd0;
        end
      end
    endcase
  end

  assign illegal_s = csr.csr_req_i &&
                     (!known_s || (csr.csr_addr_i[11:10] == 2'b11 && csr.csr_op_i != CSR_OP_READ));
  assign wr_en_s   = csr.csr_req_i && !illegal_s && csr_op_writes(csr.csr_op_i, csr.csr_wdata_i);
  assign wr_val_s  = csr_apply_op(csr.csr_op_i, rdata_s, csr.csr_wdata_i);

  assign csr.csr_rdata_o   = rdata_s;
  assign csr.csr_illegal_o = illegal_s;

  // Slot 0 = mcycle, 1 = minstret, 2+k = mhpmcounter(3+k).
  always_comb begin
    cnt_inc_s    = '0;
    cnt_inh_s    = '0;
    cnt_inc_s[0] = 1'b1;
    cnt_inc_s[1] = instret_i;
    cnt_inh_s[0] = minh_q[0];
    cnt_inh_s[1] = minh_q[2];
    for (int k = 0; k < NUM_HPM; k++) begin
      cnt_inc_s[2+k] = hpm_event_i[k];
      cnt_inh_s[2+k] = minh_q[3+k];
    end
    for (int g = 0; g < NCNT; g++) begin
      cnt_wr_lo_s[g] = wr_en_s && cnt_hit_s && !cnt_hi_s && (cnt_slot_s == 3'(g));
      cnt_wr_hi_s[g] = wr_en_s && cnt_hit_s && cnt_hi_s && (cnt_slot_s == 3'(g));
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_cnt
    if (g < NCNT) begin : g_inst
      csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (cnt_inc_s[g]),
        .inhibit_i (cnt_inh_s[g]),
        .wr_lo_i   (cnt_wr_lo_s[g]),
        .wr_hi_i   (cnt_wr_hi_s[g]),
        .wdata_i   (wr_val_s),
        .cnt_o     (cnt_val_s[g])
      );
    end else begin : g_none
      assign cnt_val_s[g] = 64'd0;
    end
  end

  // CSR writes first, then mret, then trap, so the later assignment wins.
  always_comb begin
    st_mie_d   = st_mie_q;
    st_mpie_d  = st_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    minh_d     = minh_q;
    mip_d            = 32'd0;
    mip_d[MIP_MSIP]  = irq_sw_i;
    mip_d[MIP_MTIP]  = irq_timer_i;
    mip_d[MIP_MEIP]  = irq_ext_i;
    if (wr_en_s) begin
      case (csr.csr_addr_i)
        CSR_MSTATUS: begin
          st_mie_d  = wr_val_s[MSTATUS_MIE];
          st_mpie_d = wr_val_s[MSTATUS_MPIE];
        end
        CSR_MIE:           mie_d      = wr_val_s & IRQ_MASK;
        CSR_MTVEC:         mtvec_d    = wr_val_s;
        CSR_MCOUNTINHIBIT: minh_d     = wr_val_s & INH_MASK;
        CSR_MSCRATCH:      mscratch_d = wr_val_s;
        CSR_MEPC:          mepc_d     = wr_val_s & MEPC_MASK;
        CSR_MCAUSE:        mcause_d   = wr_val_s;
        default:           mie_d      = mie_q;
      endcase
    end else begin
      mie_d = mie_q;
    end
    if (trap_i) begin
      mepc_d    = trap_epc_i & MEPC_MASK;
      mcause_d  = trap_cause_i;
      st_mpie_d = st_mie_q;
      st_mie_d  = 1'b0;
    end else if (mret_i) begin
      st_mie_d  = st_mpie_q;
      st_mpie_d = 1'b1;
    end else begin
      st_mie_d = st_mie_d;
    end
    irq_req_d = st_mie_d && ((mip_q & mie_q) != 32'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_mie_q   <= 1'b0;
      st_mpie_q  <= 1'b0;
      mie_q      <= 32'd0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= 32'd0;
      mepc_q     <= 32'd0;
      mcause_q   <= 32'd0;
      mip_q      <= 32'd0;
      minh_q     <= 32'd0;
      irq_req_q  <= 1'b0;
    end else begin
      st_mie_q   <= st_mie_d;
      st_mpie_q  <= st_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mip_q      <= mip_d;
      minh_q     <= minh_d;
      irq_req_q  <= irq_req_d;
    end
  end

  // Vectored mode only applies to interrupts.
  always_comb begin
    vec_base_s = {mtvec_q[31:2], 2'b00};
    if (mtvec_q[1:0] == 2'b01 && trap_cause_i[31]) begin
      trap_vec_o = vec_base_s + {25'd0, trap_cause_i[4:0], 2'b00};
    end else begin
      trap_vec_o = vec_base_s;
    end
  end

  assign irq_req_o    = irq_req_q;
  assign mepc_o       = mepc_q;
  assign mstatus_o    = mstatus_s;
  assign unused_hpm_s = ^hpm_event_i;

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit (CNT_WIDTH=33, NUM_HPM=2).
module tb_csr_unit;
  import csr_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        instret_i;
  logic [1:0]  hpm_event_i;
  logic        trap_i, mret_i;
  logic [31:0] trap_cause_i, trap_epc_i;
  logic        irq_sw_i, irq_timer_i, irq_ext_i;
  logic        irq_req_o;
  logic [31:0] trap_vec_o, mepc_o, mstatus_o;

  int n_checks = 0;
  int n_errors = 0;

  csr_unit_if bus ();

  csr_unit #(
    .CNT_WIDTH (33),
    .NUM_HPM   (2),
    .MTVEC_RST (32'h0000_1000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .csr          (bus.slave),
    .instret_i    (instret_i),
    .hpm_event_i  (hpm_event_i),
    .trap_i       (trap_i),
    .trap_cause_i (trap_cause_i),
    .trap_epc_i   (trap_epc_i),
    .mret_i       (mret_i),
    .irq_sw_i     (irq_sw_i),
    .irq_timer_i  (irq_timer_i),
    .irq_ext_i    (irq_ext_i),
    .irq_req_o    (irq_req_o),
    .trap_vec_o   (trap_vec_o),
    .mepc_o       (mepc_o),
    .mstatus_o    (mstatus_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string tag);
    bus.csr_req_i  = 1'b1;
    bus.csr_op_i   = CSR_OP_READ;
    bus.csr_addr_i = addr;
    #1;
    check(tag, bus.csr_rdata_o, exp);
    bus.csr_req_i  = 1'b0;
  endtask

  task automatic wr(input csr_op_e op, input logic [11:0] addr, input logic [31:0] data,
                    input logic [31:0] exp_old, input bit chk, input string tag);
    bus.csr_req_i   = 1'b1;
    bus.csr_op_i    = op;
    bus.csr_addr_i  = addr;
    bus.csr_wdata_i = data;
    #1;
    if (chk) check(tag, bus.csr_rdata_o, exp_old);
    @(posedge clk);
    #1;
    bus.csr_req_i   = 1'b0;
    bus.csr_op_i    = CSR_OP_READ;
    bus.csr_wdata_i = 32'd0;
  endtask

  initial begin
    rst = 1'b1;
    bus.csr_req_i = 1'b0; bus.csr_op_i = CSR_OP_READ;
    bus.csr_addr_i = 12'h000; bus.csr_wdata_i = 32'd0;
    instret_i = 1'b0; hpm_event_i = 2'b00; trap_i = 1'b0; mret_i = 1'b0;
    trap_cause_i = 32'd0; trap_epc_i = 32'd0;
    irq_sw_i = 1'b0; irq_timer_i = 1'b0; irq_ext_i = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_mstatus", mstatus_o, 32'h0000_1800);
    check("rst_irq", {31'd0, irq_req_o}, 32'd0);
    check("rst_mepc", mepc_o, 32'd0);
    rd(CSR_MCYCLE, 32'd0, "rst_mcycle");
    rst = 1'b0;
    cyc();
    rd(CSR_MCYCLE, 32'd1, "mcycle_1");
    cyc();
    rd(CSR_MCYCLE, 32'd2, "mcycle_2");
    rd(CSR_MTVEC, 32'h0000_1000, "mtvec_rst");
    rd(CSR_MSTATUS, 32'h0000_1800, "mstatus_rd");

    wr(CSR_OP_RS, CSR_MSTATUS, 32'h8, 32'h0000_1800, 1'b1, "ms_rs_old");
    wr(CSR_OP_RC, CSR_MSTATUS, 32'h8, 32'h0000_1808, 1'b1, "ms_rc_old");
    rd(CSR_MSTATUS, 32'h0000_1800, "ms_final");

    bus.csr_req_i = 1'b1; bus.csr_op_i = CSR_OP_RW;
    bus.csr_addr_i = CSR_CYCLE; bus.csr_wdata_i = 32'h5;
    #1;
    check("ill_wr_c00", {31'd0, bus.csr_illegal_o}, 32'd1);
    bus.csr_op_i = CSR_OP_READ;
    #1;
    check("rd_c00_legal", {31'd0, bus.csr_illegal_o}, 32'd0);
    bus.csr_addr_i = 12'hB05;
    #1;
    check("ill_b05", {31'd0, bus.csr_illegal_o}, 32'd1);
    bus.csr_addr_i = 12'hC03;
    #1;
    check("ill_c03", {31'd0, bus.csr_illegal_o}, 32'd1);
    bus.csr_op_i = CSR_OP_RW; bus.csr_addr_i = CSR_MSTATUS; bus.csr_wdata_i = 32'h0;
    bus.csr_req_i = 1'b0;
    #1;
    check("ill_no_req", {31'd0, bus.csr_illegal_o}, 32'd0);
    bus.csr_op_i = CSR_OP_READ;
    check("ill_no_change", mstatus_o, 32'h0000_1800);

    wr(CSR_OP_RW, CSR_MSCRATCH, 32'hDEAD_BEEF, 32'd0, 1'b1, "mscratch_old");
    rd(CSR_MSCRATCH, 32'hDEAD_BEEF, "mscratch");
    wr(CSR_OP_RS, CSR_MSCRATCH, 32'd0, 32'hDEAD_BEEF, 1'b1, "rs0_old");
    rd(CSR_MSCRATCH, 32'hDEAD_BEEF, "rs0_nowrite");
    wr(CSR_OP_RW, CSR_MEPC, 32'h0000_1237, 32'd0, 1'b1, "mepc_old");
    rd(CSR_MEPC, 32'h0000_1234, "mepc_align");
    check("mepc_o", mepc_o, 32'h0000_1234);

    wr(CSR_OP_RW, CSR_MCOUNTINHIBIT, 32'hFFFF_FFFF, 32'd0, 1'b1, "inh_old");
    rd(CSR_MCOUNTINHIBIT, 32'h0000_001D, "inh_mask");
    wr(CSR_OP_RW, CSR_MCYCLE, 32'h0000_1234, 32'd0, 1'b0, "");
    instret_i = 1'b1;
    repeat (10) cyc();
    instret_i = 1'b0;
    rd(CSR_MCYCLE, 32'h0000_1234, "mcycle_frozen");
    rd(CSR_MINSTRET, 32'd0, "minstret_frozen");
    wr(CSR_OP_RW, CSR_MCOUNTINHIBIT, 32'd0, 32'h0000_001D, 1'b1, "inh_clr_old");
    rd(CSR_MCYCLE, 32'h0000_1234, "mcycle_still");
    cyc();
    rd(CSR_MCYCLE, 32'h0000_1235, "mcycle_resume");

    wr(CSR_OP_RW, CSR_MCYCLE, 32'hFFFF_FFFF, 32'h0000_1235, 1'b1, "wrap_old");
    rd(CSR_MCYCLE, 32'hFFFF_FFFF, "wr_wins_lo");
    rd(CSR_MCYCLEH, 32'd0, "wr_wins_hi");
    cyc();
    rd(CSR_MCYCLE, 32'd0, "carry_lo");
    rd(CSR_MCYCLEH, 32'd1, "carry_hi");
    wr(CSR_OP_RW, CSR_MCYCLE, 32'hFFFF_FFFF, 32'd0, 1'b1, "wrap2_old");
    rd(CSR_MCYCLEH, 32'd1, "hi_holds");
    cyc();
    rd(CSR_MCYCLE, 32'd0, "wrap_lo");
    rd(CSR_MCYCLEH, 32'd0, "wrap_hi");

    instret_i = 1'b1; hpm_event_i = 2'b11;
    repeat (3) cyc();
    instret_i = 1'b0; hpm_event_i = 2'b10;
    repeat (2) cyc();
    hpm_event_i = 2'b00;
    rd(CSR_MINSTRET, 32'd3, "minstret");
    rd(CSR_INSTRET, 32'd3, "instret_ro");
    rd(CSR_MHPM3, 32'd3, "hpm3");
    rd(12'hB04, 32'd5, "hpm4");
    rd(CSR_MHPM3H, 32'd0, "hpm3h");

    wr(CSR_OP_RW, CSR_MIE, 32'h0000_0800, 32'd0, 1'b1, "mie_old");
    wr(CSR_OP_RW, CSR_MTVEC, 32'h0000_0101, 32'h0000_1000, 1'b1, "mtvec_old");
    wr(CSR_OP_RS, CSR_MSTATUS, 32'h8, 32'h0000_1800, 1'b1, "mie_set_old");
    check("mstatus_mie", mstatus_o, 32'h0000_1808);
    irq_ext_i = 1'b1;
    check("irq_0", {31'd0, irq_req_o}, 32'd0);
    cyc();
    check("irq_1", {31'd0, irq_req_o}, 32'd0);
    rd(CSR_MIP, 32'h0000_0800, "mip");
    cyc();
    check("irq_2", {31'd0, irq_req_o}, 32'd1);

    trap_i = 1'b1; trap_cause_i = 32'h8000_000B; trap_epc_i = 32'h0000_2002;
    #1;
    check("trap_vec", trap_vec_o, 32'h0000_012C);
    cyc();
    trap_i = 1'b0; irq_ext_i = 1'b0;
    check("trap_mstatus", mstatus_o, 32'h0000_1880);
    check("trap_irq_drop", {31'd0, irq_req_o}, 32'd0);
    check("trap_mepc", mepc_o, 32'h0000_2000);
    rd(CSR_MCAUSE, 32'h8000_000B, "trap_mcause");
    trap_cause_i = 32'h0000_0002;
    #1;
    check("trap_vec_exc", trap_vec_o, 32'h0000_0100);

    mret_i = 1'b1;
    cyc();
    mret_i = 1'b0;
    check("mret_mstatus", mstatus_o, 32'h0000_1888);

    trap_i = 1'b1; mret_i = 1'b1; trap_cause_i = 32'h5; trap_epc_i = 32'h0000_3000;
    bus.csr_req_i = 1'b1; bus.csr_op_i = CSR_OP_RC;
    bus.csr_addr_i = CSR_MSTATUS; bus.csr_wdata_i = 32'h80;
    cyc();
    trap_i = 1'b0; mret_i = 1'b0;
    bus.csr_req_i = 1'b0; bus.csr_op_i = CSR_OP_READ; bus.csr_wdata_i = 32'd0;
    check("prio_mstatus", mstatus_o, 32'h0000_1880);
    check("prio_mepc", mepc_o, 32'h0000_3000);

    hpm_event_i = 2'b11;
    repeat (2) cyc();
    #2;
    rst = 1'b1;
    rd(CSR_MCYCLE, 32'd0, "arst_mcycle");
    rd(CSR_MHPM3, 32'd0, "arst_hpm3");
    rd(12'hB04, 32'd0, "arst_hpm4");
    rd(CSR_MTVEC, 32'h0000_1000, "arst_mtvec");
    check("arst_mstatus", mstatus_o, 32'h0000_1800);
    check("arst_mepc", mepc_o, 32'd0);
    hpm_event_i = 2'b00;
    cyc();
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
# csr_unit

Parametrised machine-mode CSR unit that replaces the fixed-register CSR block in the core. It supports atomic read-modify-write ops (RW/RS/RC) with illegal-access detection, configurable-width cycle/instret counters with inhibit control, and up to four hardware performance counters. It also performs hardware trap entry and `mret` updates of mstatus, and generates interrupt requests from mip/mie. It sits beside the execute stage (CSR instructions) and the interrupt controller (trap/mret, vectored trap PC).

## Interface
- CNT_WIDTH, 64, counter width for mcycle/minstret/mhpmcounterN (legal 33..64; upper read bits zero-filled)
- NUM_HPM, 0, number of mhpmcounter3..(3+NUM_HPM-1) (legal 0..4)
- MTVEC_RST, 32'h0, reset value of mtvec
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset: asynchronous, active-high
- csr_req_i  in  1  CSR instruction valid this cycle
- csr_op_i  in  2  01 RW, 10 RS (set), 11 RC (clear); 00 = read only
- csr_addr_i  in  12  CSR address
- csr_wdata_i  in  32  operand (rs1 or zimm)
- csr_rdata_o  out  32  old value of addressed CSR (combinational)
- csr_illegal_o  out  1  unknown address, or write op to read-only address (addr[11:10]==11)
- instret_i  in  1  one instruction retired
- hpm_event_i  in  max(NUM_HPM,1)  per-counter event pulse
- trap_i  in  1  take trap this cycle
- trap_cause_i  in  32  mcause value (bit31 = interrupt)
- trap_epc_i  in  32  PC to save in mepc
- mret_i  in  1  mret executing
- irq_sw_i, irq_timer_i, irq_ext_i  in  1 each  level interrupt sources (mip bits 3/7/11)
- irq_req_o  out  1  registered interrupt request
- trap_vec_o  out  32  trap target PC (combinational)
- mepc_o, mstatus_o  out  32  current register values

## Operation
- Implemented CSRs: mstatus(300: bits MIE[3], MPIE[7], MPP[12:11] read 11, others 0), mie(304), mtvec(305), mscratch(340), mepc(341, bits[1:0] read 0), mcause(342), mip(344, read-only for software), mcountinhibit(320: bits 0, 2, 3..3+NUM_HPM-1 writable), mcycle/h(B00/B80), minstret/h(B02/B82), mhpmcounterN/h(B03+/B83+), cycle/h, instret/h (C00/C80/C02/C82, read-only).
- Write value: RW = wdata; RS = old|wdata; RC = old&~wdata. No write if op=00, or RS/RC with wdata=0. No write and no side effect when csr_illegal_o=1.
- Unimplemented hpm indices (≥NUM_HPM) are illegal.
- Counters: increment when not inhibited (mcycle every cycle; minstret on instret_i; hpmN on hpm_event_i[N]). A software write to either half wins over that cycle's increment; the other half holds.
- mip: sampled every cycle from irq inputs into register.
- Trap entry (trap_i): mepc←trap_epc_i, mcause←trap_cause_i, MPIE←MIE, MIE←0.
- mret_i: MIE←MPIE, MPIE←1.
- Priority in one cycle: trap_i > mret_i > CSR write. Lower-priority updates to the same fields are dropped. Counter increments are unaffected.
- trap_vec_o: mtvec[1:0]=01 and trap_cause_i[31]=1 → {mtvec[31:2],2'b0}+4·cause[4:0]; otherwise {mtvec[31:2],2'b0}.

## Timing
- Reads and csr_illegal_o are combinational; writes are visible on csr_rdata_o from the cycle after the edge.
- irq_req_o = registered (MIE & |(mip & mie)): asserted 2 cycles after an irq input rises (one for the mip sample, one for the request register), and deasserted the cycle after the edge that takes the trap (MIE cleared).
- Counter wrap: all-ones → 0, no flag.
- Reset (any time, asynchronous): mtvec=MTVEC_RST; all other registers 0, including counters, mip, mcountinhibit, MIE, MPIE. Outputs: irq_req_o=0, mepc_o=0, mstatus_o=32'h1800 (MPP reads 11).

## Structure
- Shared package/defines: CSR address constants, op encodings, mstatus bit positions, mip/mie bit positions.
- One sub-module `csr_counter` (CNT_WIDTH, inc, inhibit, lo/hi write ports), instantiated 2+NUM_HPM times via generate.

## Test plan
- Reset release → mstatus_o=32'h1800, mtvec reads MTVEC_RST, mcycle reads 1 on the first cycle after release, then 2, and so on.
- RS 0x8 then RC 0x8 to mstatus: reads return 0x1800, 0x1808; final value 0x1800. Write op to C00: csr_illegal_o=1, no state change.
- mcountinhibit=1 for 10 cycles → mcycle frozen. Write mcycle=0xFFFFFFFF with CNT_WIDTH=33 → next reads: low 0, high 1, and the high half wraps to 0 after 2^33 counts.
- mie=0x800, MIE=1, raise irq_ext_i → irq_req_o high 2 cycles later. trap_i with cause 0x8000000B, mtvec=0x101 → trap_vec_o=0x12C; MIE=0, MPIE=1, irq_req_o drops next cycle.
- mret_i → MIE=1, MPIE=1. trap_i, mret_i and a CSR write to mstatus in the same cycle → only the trap update applies.
- NUM_HPM=2: hpm_event_i pulses counted on B03/B04. B05 flagged illegal. Assert rst mid-count → all counters 0 immediately.
